// File: rtl/sysid_pkg.sv
// Shared constants for the system-identification register block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sysid_pkg;

    localparam int DATA_W         = 32;
    localparam int ADDR_W         = 4;
    localparam int BE_W           = DATA_W / 8;
    localparam int MAX_USER_WORDS = 8;

    // Word addresses on the control bus
    localparam logic [ADDR_W-1:0] ADDR_ID        = 4'd0;
    localparam logic [ADDR_W-1:0] ADDR_TS        = 4'd1;
    localparam logic [ADDR_W-1:0] ADDR_CAPS      = 4'd2;
    localparam logic [ADDR_W-1:0] ADDR_SCRATCH   = 4'd3;
    localparam logic [ADDR_W-1:0] ADDR_UPSEC     = 4'd4;
    localparam logic [ADDR_W-1:0] ADDR_UPSNAP    = 4'd5;
    localparam logic [ADDR_W-1:0] ADDR_USER_BASE = 4'd8;

    localparam logic [7:0] CAPS_VERSION = 8'h02;

    // Merge write data into a register one byte lane at a time.
    function automatic logic [DATA_W-1:0] apply_byteenable(
        input logic [DATA_W-1:0] cur,
        input logic [DATA_W-1:0] wdata,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        res = cur;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sysid_uptime_counter.sv
// Uptime seconds counter with a sub-second prescaler and a snapshot of the prescaler.
// Latency: clear and snapshot take effect on the clock edge that samples them.
// Backpressure: none; counts every clock, clear beats the terminal-count increment.
//
// Ports:
//   clock, reset   : system clock, synchronous active-high reset
//   clear          : zero prescaler, seconds and snapshot at the next edge
//   snap_req       : capture the current prescaler value into tick_snap
//   seconds        : seconds elapsed (wraps at 2^32 with no flag)
//   tick_snap      : prescaler value captured by the last snap_req
module sysid_uptime_counter
    import sysid_pkg::*;
#(
    parameter int PRESCALE = 50000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              snap_req,
    output logic [DATA_W-1:0] seconds,
    output logic [DATA_W-1:0] tick_snap
);

    localparam int              PS_W    = $clog2(PRESCALE);
    localparam logic [PS_W-1:0] PS_TERM = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

    logic [PS_W-1:0]   prescaler_q;
    logic [DATA_W-1:0] seconds_q;
    logic [DATA_W-1:0] snap_q;
    logic              terminal;

    assign terminal = (prescaler_q == PS_TERM);

    // seconds_q is only written when it actually changes, so it holds
    // any value it was given until the next increment or clear.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            prescaler_q <= '0;
            seconds_q   <= '0;
            snap_q      <= '0;
        end else begin
            if (terminal) begin
                prescaler_q <= '0;
                seconds_q   <= seconds_q + 32'd1;
            end else begin
                prescaler_q <= prescaler_q + PS_ONE;
            end
            // Capture the pre-edge prescaler, the same cycle the bus
            // samples seconds, so the pair is coherent.
            if (snap_req) begin
                snap_q <= DATA_W'(prescaler_q);
            end
        end
    end

    assign seconds   = seconds_q;
    assign tick_snap = snap_q;

endmodule

// File: rtl/sysid_info_regs.sv
// System ID / build info / scratch / uptime register slave on Avalon-MM.
// Latency: fixed READ_LATENCY clocks from read acceptance to readdatavalid.
// Backpressure: none (no waitrequest); a read coinciding with a write is dropped.
//
// Ports:
//   clock, reset     : system clock, synchronous active-high reset
//   address          : 4-bit word address
//   read, write      : transfer requests, accepted every cycle they are presented
//   writedata        : 32-bit write data
//   byteenable       : write byte lanes (SCRATCH only)
//   readdata         : read data, holds last value while readdatavalid is low
//   readdatavalid    : readdata carries the response to an accepted read
module sysid_info_regs
    import sysid_pkg::*;
#(
    parameter logic [DATA_W-1:0] SYSTEM_ID       = 32'hDE2115A0,
    parameter logic [DATA_W-1:0] TIMESTAMP       = 32'd1354258592,
    parameter int                NUM_USER_WORDS  = 4,
    parameter logic [(NUM_USER_WORDS > 0 ? DATA_W*NUM_USER_WORDS : DATA_W)-1:0]
                                 USER_WORDS      = '0,
    parameter int                READ_LATENCY    = 1,
    parameter int                UPTIME_PRESCALE = 50000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    input  logic [BE_W-1:0]   byteenable,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid
);

    // ------------------------------------------------------------------
    // Parameter legality
    // ------------------------------------------------------------------
    if (NUM_USER_WORDS < 0 || NUM_USER_WORDS > MAX_USER_WORDS) begin : g_err_user
        $error("sysid_info_regs: NUM_USER_WORDS must be in 0..8");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_err_lat
        $error("sysid_info_regs: READ_LATENCY must be in 1..3");
    end
    if (UPTIME_PRESCALE < 2) begin : g_err_ps
        $error("sysid_info_regs: UPTIME_PRESCALE must be at least 2");
    end

    localparam logic [DATA_W-1:0] CAPS_WORD =
        {CAPS_VERSION, 8'h00, 8'(NUM_USER_WORDS), 8'(READ_LATENCY)};

    // ------------------------------------------------------------------
    // Transfer qualification
    // ------------------------------------------------------------------
    logic rd_acc;
    logic wr_scratch;
    logic wr_upsec;

    assign rd_acc     = read && !write;
    assign wr_scratch = write && (address == ADDR_SCRATCH);
    assign wr_upsec   = write && (address == ADDR_UPSEC);

    // ------------------------------------------------------------------
    // User words: unpack into a full 8-entry table, unused entries read 0
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] user_word [MAX_USER_WORDS];

    for (genvar k = 0; k < MAX_USER_WORDS; k++) begin : g_user
        if (k < NUM_USER_WORDS) begin : g_used
            assign user_word[k] = USER_WORDS[DATA_W*k +: DATA_W];
        end else begin : g_unused
            assign user_word[k] = '0;
        end
    end

    // ------------------------------------------------------------------
    // SCRATCH
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] scratch_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            scratch_q <= '0;
        end else if (wr_scratch) begin
            scratch_q <= apply_byteenable(scratch_q, writedata, byteenable);
        end
    end

    // ------------------------------------------------------------------
    // Uptime
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] up_seconds;
    logic [DATA_W-1:0] up_tick_snap;

    sysid_uptime_counter #(
        .PRESCALE (UPTIME_PRESCALE)
    ) u_uptime (
        .clock     (clock),
        .reset     (reset),
        .clear     (wr_upsec),
        .snap_req  (rd_acc && (address == ADDR_UPSEC)),
        .seconds   (up_seconds),
        .tick_snap (up_tick_snap)
    );

    // ------------------------------------------------------------------
    // Read mux, evaluated at acceptance
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_ID:      rd_mux = SYSTEM_ID;
            ADDR_TS:      rd_mux = TIMESTAMP;
            ADDR_CAPS:    rd_mux = CAPS_WORD;
            ADDR_SCRATCH: rd_mux = scratch_q;
            ADDR_UPSEC:   rd_mux = up_seconds;
            ADDR_UPSNAP:  rd_mux = up_tick_snap;
            default: begin
                // The user region starts at 8, so bit 3 selects it and the
                // low three bits index the table directly.
                if (address[3]) begin
                    rd_mux = user_word[address[2:0]];
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read pipeline: each stage only loads data alongside a valid, so the
    // last stage naturally holds the previous response while idle.
    // ------------------------------------------------------------------
    logic [READ_LATENCY-1:0] vld_q;
    logic [DATA_W-1:0]       dat_q [READ_LATENCY];

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= rd_acc;
            if (rd_acc) begin
                dat_q[0] <= rd_mux;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign readdata      = dat_q[READ_LATENCY-1];
    assign readdatavalid = vld_q[READ_LATENCY-1];

endmodule

// File: tb/tb_sysid_info_regs.sv
// Directed bench for sysid_info_regs: three instances share one bus,
// with READ_LATENCY 1, 2 and 3 and a prescale of 4 clocks per second.
module tb_sysid_info_regs;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;

    logic [31:0] rd1, rd2, rd3;
    logic        v1, v2, v3;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0]  SYS_ID = 32'hDE2115A0;
    localparam logic [31:0]  TS     = 32'd1354258592;
    localparam logic [127:0] UW     = 128'h44444444_33333333_22222222_11111111;

    always #5 clock = ~clock;

    sysid_info_regs #(.NUM_USER_WORDS(4), .USER_WORDS(UW), .READ_LATENCY(1), .UPTIME_PRESCALE(4)) dut1 (
        .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .readdata(rd1), .readdatavalid(v1));

    sysid_info_regs #(.NUM_USER_WORDS(4), .USER_WORDS(UW), .READ_LATENCY(2), .UPTIME_PRESCALE(4)) dut2 (
        .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .readdata(rd2), .readdatavalid(v2));

    sysid_info_regs #(.NUM_USER_WORDS(4), .USER_WORDS(UW), .READ_LATENCY(3), .UPTIME_PRESCALE(4)) dut3 (
        .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .readdata(rd3), .readdatavalid(v3));

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        read = 1'b0; write = 1'b0; address = 4'd0; writedata = 32'd0; byteenable = 4'd0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        tick(); tick();
        checks++; if (v1 !== 1'b0 || v2 !== 1'b0 || v3 !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b%b%b exp 000", v1, v2, v3); end
        checks++; if (rd1 !== 32'd0 || rd3 !== 32'd0) begin errors++; $display("FAIL reset_data: got %h/%h exp 0", rd1, rd3); end
        reset = 1'b0;
        tick();
        checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL idle_vld: got %b exp 0", v1); end
        read = 1'b1; address = 4'd0; tick();
        checks++; if (v1 !== 1'b1 || rd1 !== SYS_ID) begin errors++; $display("FAIL rd_id: vld=%b data=%h exp 1/%h", v1, rd1, SYS_ID); end
        address = 4'd1; tick();
        checks++; if (v1 !== 1'b1 || rd1 !== TS) begin errors++; $display("FAIL rd_ts: vld=%b data=%h exp 1/%h", v1, rd1, TS); end
        address = 4'd2; tick();
        checks++; if (v1 !== 1'b1 || rd1 !== 32'h02000401) begin errors++; $display("FAIL rd_caps: vld=%b data=%h exp 1/02000401", v1, rd1); end
        idle(); tick();
        checks++; if (v1 !== 1'b0 || rd1 !== 32'h02000401) begin errors++; $display("FAIL hold_caps: vld=%b data=%h exp 0/02000401", v1, rd1); end
        tick();
        checks++; if (v3 !== 1'b1 || rd3 !== 32'h02000403) begin errors++; $display("FAIL rd_caps_l3: vld=%b data=%h exp 1/02000403", v3, rd3); end
        tick();
    endtask

    task automatic test_scratch();
        idle();
        write = 1'b1; address = 4'd3; writedata = 32'h12345678; byteenable = 4'b1111; tick();
        writedata = 32'hAABBCCDD; byteenable = 4'b0101; tick();
        idle(); read = 1'b1; address = 4'd3; tick();
        checks++; if (v1 !== 1'b1 || rd1 !== 32'h12BB56DD) begin errors++; $display("FAIL scratch_be: vld=%b data=%h exp 1/12BB56DD", v1, rd1); end
        idle(); write = 1'b1; address = 4'd0; writedata = 32'h0BADBEEF; byteenable = 4'b1111; tick();
        idle(); read = 1'b1; address = 4'd0; tick();
        checks++; if (v1 !== 1'b1 || rd1 !== SYS_ID) begin errors++; $display("FAIL ro_write: vld=%b data=%h exp 1/%h", v1, rd1, SYS_ID); end
        idle(); tick();
        read = 1'b1; write = 1'b1; address = 4'd3; writedata = 32'hCAFEF00D; byteenable = 4'b1111; tick();
        checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL rw_same_cycle: vld=%b exp 0", v1); end
        idle(); read = 1'b1; address = 4'd3; tick();
        checks++; if (v1 !== 1'b1 || rd1 !== 32'hCAFEF00D) begin errors++; $display("FAIL rd_after_wr: vld=%b data=%h exp 1/CAFEF00D", v1, rd1); end
        idle(); tick(); tick(); tick();
    endtask

    task automatic test_back_to_back();
        idle(); tick();
        read = 1'b1; address = 4'd0; tick();
        checks++; if (v1 !== 1'b1 || rd1 !== SYS_ID || v3 !== 1'b0) begin errors++; $display("FAIL b2b_e1: v1=%b rd1=%h v3=%b exp 1/%h/0", v1, rd1, v3, SYS_ID); end
        address = 4'd3; tick();
        checks++; if (v1 !== 1'b1 || rd1 !== 32'hCAFEF00D || v3 !== 1'b0) begin errors++; $display("FAIL b2b_e2: v1=%b rd1=%h v3=%b exp 1/CAFEF00D/0", v1, rd1, v3); end
        address = 4'd8; tick();
        checks++; if (v1 !== 1'b1 || rd1 !== 32'h11111111) begin errors++; $display("FAIL b2b_user0: vld=%b data=%h exp 1/11111111", v1, rd1); end
        checks++; if (v3 !== 1'b1 || rd3 !== SYS_ID) begin errors++; $display("FAIL l3_first: vld=%b data=%h exp 1/%h", v3, rd3, SYS_ID); end
        idle(); tick();
        checks++; if (v3 !== 1'b1 || rd3 !== 32'hCAFEF00D) begin errors++; $display("FAIL l3_second: vld=%b data=%h exp 1/CAFEF00D", v3, rd3); end
        checks++; if (v2 !== 1'b1 || rd2 !== 32'h11111111) begin errors++; $display("FAIL l2_third: vld=%b data=%h exp 1/11111111", v2, rd2); end
        checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL b2b_l1_done: vld=%b exp 0", v1); end
        tick();
        checks++; if (v3 !== 1'b1 || rd3 !== 32'h11111111) begin errors++; $display("FAIL l3_third: vld=%b data=%h exp 1/11111111", v3, rd3); end
        tick();
        checks++; if (v3 !== 1'b0 || rd3 !== 32'h11111111) begin errors++; $display("FAIL l3_hold: vld=%b data=%h exp 0/11111111", v3, rd3); end
        read = 1'b1; address = 4'd9; tick();
        checks++; if (v1 !== 1'b1 || rd1 !== 32'h22222222) begin errors++; $display("FAIL rd_user1: vld=%b data=%h exp 1/22222222", v1, rd1); end
        address = 4'd15; tick();
        checks++; if (v1 !== 1'b1 || rd1 !== 32'd0) begin errors++; $display("FAIL rd_addr15: vld=%b data=%h exp 1/0", v1, rd1); end
        address = 4'd11; tick();
        checks++; if (v1 !== 1'b1 || rd1 !== 32'h44444444) begin errors++; $display("FAIL rd_user3: vld=%b data=%h exp 1/44444444", v1, rd1); end
        address = 4'd12; tick();
        checks++; if (v1 !== 1'b1 || rd1 !== 32'd0) begin errors++; $display("FAIL rd_past_user: vld=%b data=%h exp 1/0", v1, rd1); end
        address = 4'd6; tick();
        checks++; if (v1 !== 1'b1 || rd1 !== 32'd0) begin errors++; $display("FAIL rd_reserved: vld=%b data=%h exp 1/0", v1, rd1); end
        idle(); tick(); tick(); tick();
    endtask

    task automatic test_uptime();
        do_reset();
        repeat (10) tick();
        read = 1'b1; address = 4'd4; tick();
        checks++; if (v1 !== 1'b1 || rd1 !== 32'd2) begin errors++; $display("FAIL uptime_sec: vld=%b data=%0d exp 1/2", v1, rd1); end
        address = 4'd5; tick();
        checks++; if (v1 !== 1'b1 || rd1 !== 32'd2) begin errors++; $display("FAIL uptime_snap: vld=%b data=%0d exp 1/2", v1, rd1); end
        idle(); tick(); tick(); tick();
        write = 1'b1; address = 4'd4; writedata = 32'h0; byteenable = 4'b1111; tick();
        idle(); read = 1'b1; address = 4'd5; tick();
        checks++; if (v1 !== 1'b1 || rd1 !== 32'd0) begin errors++; $display("FAIL clear_snap: vld=%b data=%0d exp 1/0", v1, rd1); end
        address = 4'd4; tick();
        checks++; if (v1 !== 1'b1 || rd1 !== 32'd0) begin errors++; $display("FAIL clear_at_tc: vld=%b data=%0d exp 1/0", v1, rd1); end
        idle(); tick();
    endtask

    task automatic test_wrap();
        do_reset();
        force dut1.u_uptime.seconds_q = 32'hFFFFFFFF;
        tick();
        release dut1.u_uptime.seconds_q;
        read = 1'b1; address = 4'd4; tick();
        checks++; if (v1 !== 1'b1 || rd1 !== 32'hFFFFFFFF) begin errors++; $display("FAIL wrap_pre: vld=%b data=%h exp 1/FFFFFFFF", v1, rd1); end
        idle(); tick(); tick();
        read = 1'b1; address = 4'd4; tick();
        checks++; if (v1 !== 1'b1 || rd1 !== 32'd0) begin errors++; $display("FAIL wrap_post: vld=%b data=%h exp 1/0", v1, rd1); end
        idle(); tick();
    endtask

    task automatic test_reset_mid_read();
        idle();
        read = 1'b1; address = 4'd0; tick();
        idle(); tick();
        checks++; if (v2 !== 1'b1 || rd2 !== SYS_ID) begin errors++; $display("FAIL l2_id: vld=%b data=%h exp 1/%h", v2, rd2, SYS_ID); end
        write = 1'b1; address = 4'd3; writedata = 32'h5A5A5A5A; byteenable = 4'b1111; tick();
        idle(); read = 1'b1; address = 4'd3; tick();
        idle(); reset = 1'b1; tick();
        checks++; if (v2 !== 1'b0 || rd2 !== 32'd0) begin errors++; $display("FAIL midrd_reset: vld=%b data=%h exp 0/0", v2, rd2); end
        reset = 1'b0; tick();
        checks++; if (v2 !== 1'b0) begin errors++; $display("FAIL midrd_flush1: vld=%b exp 0", v2); end
        tick();
        checks++; if (v2 !== 1'b0) begin errors++; $display("FAIL midrd_flush2: vld=%b exp 0", v2); end
        read = 1'b1; address = 4'd3; tick();
        idle();
        checks++; if (v2 !== 1'b0) begin errors++; $display("FAIL l2_early: vld=%b exp 0", v2); end
        tick();
        checks++; if (v2 !== 1'b1 || rd2 !== 32'd0) begin errors++; $display("FAIL scratch_after_rst: vld=%b data=%h exp 1/0", v2, rd2); end
        tick();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        test_reset();
        test_scratch();
        test_back_to_back();
        test_uptime();
        test_wrap();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sysid_info_regs.md
Name: sysid_info_regs

Overview:
Parametrised system-identification and info register slave on the Avalon-MM control bus.
- Returns a fixed system ID, a build timestamp and a capability word.
- Holds a software scratch register and a free-running uptime counter with a coherent snapshot.
- Holds N build-time user words.
- Reads use a fixed, parametrised pipelined latency with readdatavalid, so the CPU driver can probe board configuration and check that the bus is alive.

Parameters:
- SYSTEM_ID, 32'hDE2115A0: constant returned at word 0.
- TIMESTAMP, 32'd1354258592: build time in Unix seconds, returned at word 1.
- NUM_USER_WORDS, 4: number of user info words, range 0..8.
- USER_WORDS, all zeros: packed 32*NUM_USER_WORDS constant; word k sits at bits [32k+31:32k].
- READ_LATENCY, 1: read data latency in clocks, range 1..3.
- UPTIME_PRESCALE, 50000000: clocks per uptime second; must be at least 2.

Ports:
- clock, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- address, in, 4: word address.
- read, in, 1: read request, one word per asserted cycle.
- write, in, 1: write request.
- writedata, in, 32: write data.
- byteenable, in, 4: byte lanes for writes.
- readdata, out, 32: read data.
- readdatavalid, out, 1: readdata is valid this cycle.

Behaviour:
- One clock; reset is synchronous and active-high.
- No waitrequest. A transfer is accepted in every cycle it is presented.
- Register map:
  - 0 ID (read-only).
  - 1 TIMESTAMP (read-only).
  - 2 CAPS (read-only): [31:24] = 8'h02 version, [23:16] = 0, [15:8] = NUM_USER_WORDS, [7:0] = READ_LATENCY.
  - 3 SCRATCH (read/write, byteenable honoured).
  - 4 UPTIME_SEC (read-only; any write clears it).
  - 5 UPTIME_TICK_SNAP (read-only).
  - 6..7 reserved, read 0.
  - 8..8+N-1 USER_WORDS[k].
  - 8+N..15 read 0.
- Read pipeline:
  - A read sampled in cycle T produces readdatavalid=1 with data in cycle T+READ_LATENCY.
  - Back-to-back reads give back-to-back valids, in order.
  - Data is selected at acceptance. The pipeline delays a captured value; it does not re-sample at output time.
  - readdata holds its last value while readdatavalid=0.
- Write and read in the same cycle: the write is performed and the read is dropped (no readdatavalid for it).
- A read in the cycle after a write returns the written value.
- Writes to read-only or reserved words have no effect, except the UPTIME_SEC clear described below.
- Uptime counter:
  - The prescaler counts 0..UPTIME_PRESCALE-1.
  - At terminal count the prescaler returns to 0 and the seconds counter increments.
  - The seconds counter wraps from 32'hFFFFFFFF to 0 with no sticky flag.
- Snapshot:
  - An accepted read of word 4 captures the prescaler value at acceptance into UPTIME_TICK_SNAP.
  - The returned seconds value and the snapshot are coherent: both are taken in the same cycle.
- Clear:
  - A write to word 4 zeroes the seconds counter, the prescaler and the snapshot in the next cycle.
  - A clear coinciding with a prescaler terminal count wins, so seconds = 0.
- Reset values: readdata=0, readdatavalid=0, SCRATCH=0, seconds=0, prescaler=0, snapshot=0.
- Reset during in-flight reads: the pipeline is flushed, no valid is emitted for pending reads, and readdatavalid=0 from the first cycle after reset is sampled.
- Elaboration errors:
  - NUM_USER_WORDS > 8.
  - READ_LATENCY outside 1..3.
  - UPTIME_PRESCALE < 2.

Decomposition:
- Shared package sysid_pkg:
  - Word-address localparams: ADDR_ID=0, ADDR_TS=1, ADDR_CAPS=2, ADDR_SCRATCH=3, ADDR_UPSEC=4, ADDR_UPSNAP=5, ADDR_USER_BASE=8.
  - CAPS_VERSION=8'h02.
  - Data width constant 32.
- Sub-module sysid_uptime_counter:
  - Owns the prescaler, the seconds counter and the snapshot.
  - Inputs: clear and snap_req.
  - Outputs: seconds and tick_snap.
- The top level holds address decode, SCRATCH and the readdata/readdatavalid shift pipeline.

Test Plan:
- Reset sequence: after reset, read words 0, 1, 2 with READ_LATENCY=1 -> 32'hDE2115A0, 32'd1354258592, 32'h02000401; each valid exactly 1 cycle after its read, with no valid at any other time.
- SCRATCH byte lanes:
  - Write 32'h12345678 with byteenable 4'b1111, then write 32'hAABBCCDD with byteenable 4'b0101, then read -> 32'h12BB56DD.
  - Read in the same cycle as a write -> no readdatavalid for that read.
- Latency and back-to-back reads:
  - READ_LATENCY=3: reads of words 0, 3, 8 on consecutive cycles -> three consecutive valids starting 3 cycles later, in order.
  - Address 15 reads 0.
- Uptime with UPTIME_PRESCALE=4:
  - After 10 clocks post-reset, read word 4 -> seconds = 2 and snapshot (word 5) = 2.
  - Write word 4 in the same cycle as a terminal count -> seconds = 0.
- Wrap: force seconds to 32'hFFFFFFFF, run one prescale period -> 0.
- Reset mid-read: with READ_LATENCY=2, assert reset one cycle after a read -> no readdatavalid for that read; readdata=0 and SCRATCH=0 after reset.
